// File: rtl/ioctl_pkg.sv
// Definitions shared by the IO-bank timed-output controllers and input monitors.
package ioctl_pkg;

    localparam int unsigned IOCTL_CNT_W = 32;

    typedef enum logic [2:0] {
        CAP_IDLE      = 3'd0,
        CAP_ARMED     = 3'd1,
        CAP_WAIT_EDGE = 3'd2,
        CAP_IN_PULSE  = 3'd3,
        CAP_DONE      = 3'd4
    } cap_state_e;

endpackage

// File: rtl/io_input_sync.sv
// Multi-flop synchronizer for an asynchronous IO line, with a delayed copy
// for leading-edge detection into a selectable active level.
module io_input_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rst_val_i,
    input  logic active_level_i,
    input  logic d_i,
    output logic sync_o,
    output logic lead_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {SYNC_STAGES{rst_val_i}};
            prev_q <= rst_val_i;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign lead_o = (sync_o == active_level_i) && (prev_q != active_level_i);

endmodule

// File: rtl/io_pulse_capture.sv
// Armed/triggered capture of trigger-to-leading-edge delay and pulse width
// on one external IO line; result held until disarmed.
module io_pulse_capture
    import ioctl_pkg::*;
#(
    parameter int unsigned CNT_W       = IOCTL_CNT_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hardStop,
    input  logic             activeLevel,
    input  logic             onYourMark,
    input  logic             GOGOGO_EXCLAMATION,
    input  logic [CNT_W-1:0] timeout,
    input  logic             ioIn,
    output logic [CNT_W-1:0] measuredDelay,
    output logic [CNT_W-1:0] measuredWidth,
    output logic             captureComplete,
    output logic             captureTimeout,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    cap_state_e       state_q;
    logic [CNT_W-1:0] delay_cnt_q;
    logic [CNT_W-1:0] width_cnt_q;
    logic [CNT_W-1:0] tl_timeout_q;
    logic [CNT_W-1:0] meas_delay_q;
    logic [CNT_W-1:0] meas_width_q;
    logic             complete_q;
    logic             timeout_q;
    logic             busy_q;

    logic             sync_in;
    logic             lead;
    logic [CNT_W-1:0] delay_inc_d;
    logic [CNT_W-1:0] width_inc_d;
    logic             timeout_hit;

    io_input_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i         (clk),
        .rst_i         (rst),
        .rst_val_i     (~activeLevel),
        .active_level_i(activeLevel),
        .d_i           (ioIn),
        .sync_o        (sync_in),
        .lead_o        (lead)
    );

    // Counters saturate at all-ones rather than wrapping.
    assign delay_inc_d = (&delay_cnt_q) ? delay_cnt_q : delay_cnt_q + CNT_ONE;
    assign width_inc_d = (&width_cnt_q) ? width_cnt_q : width_cnt_q + CNT_ONE;
    assign timeout_hit = (tl_timeout_q != '0) && ((delay_cnt_q + CNT_ONE) == tl_timeout_q);

    always_ff @(posedge clk) begin
        if (rst || hardStop) begin
            state_q      <= CAP_IDLE;
            delay_cnt_q  <= '0;
            width_cnt_q  <= '0;
            tl_timeout_q <= '0;
            meas_delay_q <= '0;
            meas_width_q <= '0;
            complete_q   <= 1'b0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            unique case (state_q)
                CAP_IDLE: begin
                    if (onYourMark) state_q <= CAP_ARMED;
                end
                CAP_ARMED: begin
                    if (!onYourMark) begin
                        state_q <= CAP_IDLE;
                    end else if (GOGOGO_EXCLAMATION) begin
                        state_q      <= CAP_WAIT_EDGE;
                        tl_timeout_q <= timeout;
                        delay_cnt_q  <= '0;
                        busy_q       <= 1'b1;
                    end
                end
                CAP_WAIT_EDGE: begin
                    // A leading edge seen on the timeout cycle still counts as a pulse.
                    if (!onYourMark) begin
                        state_q <= CAP_IDLE;
                        busy_q  <= 1'b0;
                    end else if (lead) begin
                        state_q      <= CAP_IN_PULSE;
                        meas_delay_q <= delay_cnt_q;
                        width_cnt_q  <= CNT_ONE;
                    end else if (timeout_hit) begin
                        state_q      <= CAP_DONE;
                        meas_delay_q <= tl_timeout_q;
                        meas_width_q <= '0;
                        complete_q   <= 1'b1;
                        timeout_q    <= 1'b1;
                        busy_q       <= 1'b0;
                    end else begin
                        delay_cnt_q <= delay_inc_d;
                    end
                end
                CAP_IN_PULSE: begin
                    if (!onYourMark) begin
                        state_q <= CAP_IDLE;
                        busy_q  <= 1'b0;
                    end else if (sync_in == activeLevel) begin
                        width_cnt_q <= width_inc_d;
                    end else begin
                        state_q      <= CAP_DONE;
                        meas_width_q <= width_cnt_q;
                        complete_q   <= 1'b1;
                        busy_q       <= 1'b0;
                    end
                end
                CAP_DONE: begin
                    if (!onYourMark) begin
                        state_q    <= CAP_IDLE;
                        complete_q <= 1'b0;
                        timeout_q  <= 1'b0;
                    end
                end
                default: state_q <= CAP_IDLE;
            endcase
        end
    end

    assign measuredDelay   = meas_delay_q;
    assign measuredWidth   = meas_width_q;
    assign captureComplete = complete_q;
    assign captureTimeout  = timeout_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_io_pulse_capture.sv
// Self-checking bench for io_pulse_capture: directed scenarios plus random
// pulse trains compared against an edge-index reference model.
module tb_io_pulse_capture;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hardStop = 1'b0;
    logic        activeLevel = 1'b1;
    logic        onYourMark = 1'b0;
    logic        go = 1'b0;
    logic [31:0] timeout = '0;
    logic [3:0]  timeout_s = '0;
    logic        ioIn = 1'b0;

    logic [31:0] measuredDelay, measuredWidth;
    logic        captureComplete, captureTimeout, busy;
    logic [3:0]  measuredDelay_s, measuredWidth_s;
    logic        captureComplete_s, captureTimeout_s, busy_s;

    int tests = 0;
    int fails = 0;

    io_pulse_capture #(.CNT_W(32), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst(rst), .hardStop(hardStop), .activeLevel(activeLevel),
        .onYourMark(onYourMark), .GOGOGO_EXCLAMATION(go), .timeout(timeout), .ioIn(ioIn),
        .measuredDelay(measuredDelay), .measuredWidth(measuredWidth),
        .captureComplete(captureComplete), .captureTimeout(captureTimeout), .busy(busy)
    );

    io_pulse_capture #(.CNT_W(4), .SYNC_STAGES(S)) dut_s (
        .clk(clk), .rst(rst), .hardStop(hardStop), .activeLevel(activeLevel),
        .onYourMark(onYourMark), .GOGOGO_EXCLAMATION(go), .timeout(timeout_s), .ioIn(ioIn),
        .measuredDelay(measuredDelay_s), .measuredWidth(measuredWidth_s),
        .captureComplete(captureComplete_s), .captureTimeout(captureTimeout_s), .busy(busy_s)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Line level seen by the clock edge j (edge 0 samples the trigger); each
    // nonzero t flips the line from edge t onwards.
    function automatic logic lvl_at(input logic lvl0, input int t1, t2, t3, input int j);
        logic v;
        v = lvl0;
        if (t1 > 0 && j >= t1) v = ~v;
        if (t2 > 0 && j >= t2) v = ~v;
        if (t3 > 0 && j >= t3) v = ~v;
        return v;
    endfunction

    // A level change first seen at edge j becomes visible to the capture
    // logic S edges later, and the delay count at edge n is n-1.
    task automatic model(input logic act, lvl0, input int t1, t2, t3, tmo, w,
                         output longint e_delay, e_width, e_to, e_edge);
        longint maxv;
        int j, j2;
        maxv = (64'd1 << w) - 1;
        j = 100000;
        for (int k = 1; k < 1000; k++)
            if (lvl_at(lvl0, t1, t2, t3, k) == act && lvl_at(lvl0, t1, t2, t3, k-1) != act) begin
                j = k;
                break;
            end
        if (tmo != 0 && j + S > tmo) begin
            e_to = 1; e_delay = tmo; e_width = 0; e_edge = tmo;
        end else begin
            j2 = j + 1;
            while (j2 < 1000 && lvl_at(lvl0, t1, t2, t3, j2) == act) j2++;
            e_to = 0;
            e_delay = (j + S - 1 > maxv) ? maxv : j + S - 1;
            e_width = (j2 - j > maxv) ? maxv : j2 - j;
            e_edge = j2 + S;
        end
    endtask

    // kind: 0 full capture, 1 hardStop, 2 rst+hardStop, 3 disarm; abort at edge abort_n
    task automatic capture(input string tag, input logic act, lvl0, input int t1, t2, t3, tmo,
                           input int kind, abort_n);
        longint d, w, to, ed, ds, ws, tos, eds;
        logic [31:0] prev_d, prev_w;
        int done_n;
        logic busy_ok;
        prev_d = measuredDelay;
        prev_w = measuredWidth;
        @(negedge clk);
        activeLevel = act; ioIn = lvl0; timeout = tmo; onYourMark = 1'b1; go = 1'b0;
        repeat (4) @(negedge clk);
        go = 1'b1;
        @(posedge clk); #1;
        check({tag, "_busy_trig"}, busy, 1);
        model(act, lvl0, t1, t2, t3, tmo, 32, d, w, to, ed);
        model(act, lvl0, t1, t2, t3, 0, 4, ds, ws, tos, eds);
        done_n = 0;
        busy_ok = 1'b1;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            go = 1'b0;
            ioIn = lvl_at(lvl0, t1, t2, t3, n);
            if (n == abort_n) begin
                if (kind == 1) hardStop = 1'b1;
                if (kind == 2) begin rst = 1'b1; hardStop = 1'b1; end
                if (kind == 3) onYourMark = 1'b0;
            end
            @(posedge clk); #1;
            if (kind != 0 && n == abort_n) break;
            if (captureComplete === 1'b1) begin done_n = n; break; end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        if (kind == 0) begin
            check({tag, "_done_edge"}, done_n, ed);
            check({tag, "_delay"}, measuredDelay, d);
            check({tag, "_width"}, measuredWidth, w);
            check({tag, "_tmoflag"}, captureTimeout, to);
            check({tag, "_busy_during"}, busy_ok, 1);
            check({tag, "_busy_done"}, busy, 0);
            if (tmo == 0) begin
                check({tag, "_s_complete"}, captureComplete_s, 1);
                check({tag, "_s_delay"}, measuredDelay_s, ds);
                check({tag, "_s_width"}, measuredWidth_s, ws);
            end
            @(negedge clk);
            onYourMark = 1'b0;
            @(posedge clk); #1;
            check({tag, "_disarm_cc"}, captureComplete, 0);
            check({tag, "_disarm_to"}, captureTimeout, 0);
            check({tag, "_disarm_delay"}, measuredDelay, d);
            check({tag, "_disarm_width"}, measuredWidth, w);
        end else if (kind == 3) begin
            check({tag, "_busy"}, busy, 0);
            check({tag, "_cc"}, captureComplete, 0);
            check({tag, "_delay_kept"}, measuredDelay, prev_d);
            check({tag, "_width_kept"}, measuredWidth, prev_w);
        end else begin
            check({tag, "_cc"}, captureComplete, 0);
            check({tag, "_to"}, captureTimeout, 0);
            check({tag, "_busy"}, busy, 0);
            check({tag, "_delay"}, measuredDelay, 0);
            check({tag, "_width"}, measuredWidth, 0);
            @(negedge clk);
            rst = 1'b0; hardStop = 1'b0; onYourMark = 1'b0;
        end
        @(negedge clk);
        onYourMark = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic a, l;
        int t1, t2, t3, tm;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cc", captureComplete, 0);
        check("rst_to", captureTimeout, 0);
        check("rst_busy", busy, 0);
        check("rst_delay", measuredDelay, 0);
        check("rst_width", measuredWidth, 0);
        @(negedge clk);
        rst = 1'b0;

        // Arm and trigger together from IDLE only arms; trigger honoured a cycle later.
        onYourMark = 1'b1; go = 1'b1;
        @(posedge clk); #1;
        check("armgo_first", busy, 0);
        @(posedge clk); #1;
        check("armgo_second", busy, 1);
        @(negedge clk);
        onYourMark = 1'b0; go = 1'b0;
        @(posedge clk); #1;
        check("armgo_disarm", busy, 0);
        repeat (2) @(negedge clk);

        capture("basic", 1'b1, 1'b0, 19, 69, 0, 0, 0, 0);
        capture("timeout", 1'b1, 1'b0, 0, 0, 0, 100, 0, 0);
        capture("preactive", 1'b0, 1'b0, 10, 30, 45, 0, 0, 0);
        capture("lead_vs_tmo", 1'b1, 1'b0, 8, 20, 0, 10, 0, 0);
        capture("tmo_by_one", 1'b1, 1'b0, 9, 20, 0, 10, 0, 0);
        capture("hardstop", 1'b1, 1'b0, 10, 60, 0, 0, 1, 30);
        capture("rearm1", 1'b1, 1'b0, 7, 27, 0, 0, 0, 0);
        capture("rst_hardstop", 1'b1, 1'b0, 10, 60, 0, 0, 2, 30);
        capture("rearm2", 1'b0, 1'b1, 12, 13, 0, 0, 0, 0);
        capture("saturate", 1'b1, 1'b0, 3, 23, 0, 0, 0, 0);
        capture("soft_abort", 1'b1, 1'b0, 40, 50, 0, 0, 3, 15);

        for (int i = 0; i < 10; i++) begin
            a  = 1'($urandom_range(0, 1));
            l  = 1'($urandom_range(0, 1));
            t1 = $urandom_range(1, 30);
            t2 = t1 + $urandom_range(1, 30);
            t3 = t2 + $urandom_range(1, 30);
            tm = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 80) : 0;
            capture($sformatf("rand%0d", i), a, l, t1, t2, t3, tm, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
